branch_resolve_unit: RTL and testbench

- Execute-side counterpart of the branch predictor.
- Records each prediction issued at fetch in an in-order queue.
- When execute resolves a branch, compares the actual outcome with the oldest recorded prediction, then:
  - sends the training update (pc, actually-taken) back to the predictor;
  - on a mispredict, issues a one-cycle pipeline flush with the correct redirect PC.
- Sits between fetch/BPU and the execute stage; also keeps branch and mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: queues fetch-time predictions in order, checks them
// against resolved outcomes, trains the predictor and raises a flush on a mispredict.
module branch_resolve_unit #(
  parameter int N              = 32,
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pred_valid,
  input  logic [N-1:0] i_pred_pc,
  input  logic         i_pred_taken,
  input  logic [N-1:0] i_pred_target,
  output logic         o_pred_ready,
  input  logic         i_res_valid,
  input  logic [N-1:0] i_res_pc,
  input  logic         i_res_taken,
  input  logic [N-1:0] i_res_target,
  output logic         o_upd_valid,
  output logic [N-1:0] o_upd_pc,
  output logic         o_upd_taken,
  output logic         o_flush,
  output logic [N-1:0] o_redirect_pc,
  output logic         o_order_err,
  output logic [31:0]  o_branch_cnt,
  output logic [31:0]  o_mispred_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [REC_W-1:0]   rec_cnt;

  logic [N-1:0]       q_pc  [DEPTH];
  logic               q_taken [DEPTH];
  logic [N-1:0]       q_tgt [DEPTH];

  logic               vld_p1, upd_taken_p1, flush_p1, order_err_p1;
  logic [N-1:0]       upd_pc_p1, redirect_p1;
  logic [31:0]        branch_cnt_p1, mispred_cnt_p1;

  logic               pred_ready, push, res_ok, mispred;
  logic [N-1:0]       head_pc, head_tgt;
  logic               head_taken;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [N-1:0] next_pc(input logic taken, input logic [N-1:0] pc,
                                           input logic [N-1:0] tgt);
    return taken ? tgt : pc + N'(4);
  endfunction

  always_comb begin
    head_pc    = q_pc[rd_ptr];
    head_taken = q_taken[rd_ptr];
    head_tgt   = q_tgt[rd_ptr];
    pred_ready = (state == RUN) && (count < DEPTH_C);
    push       = i_pred_valid && pred_ready;
    res_ok     = (state == RUN) && i_res_valid && (count != '0);
    // A target only matters when both sides agree the branch was taken.
    mispred    = (head_taken != i_res_taken) ||
                 (head_taken && i_res_taken && (head_tgt != i_res_target));
  end

  assign o_pred_ready = pred_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= i_pred_pc;
      q_taken[wr_ptr] <= i_pred_taken;
      q_tgt[wr_ptr]   <= i_pred_target;
    end
  end

  // Stage p1: resolution results registered one cycle after the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      rec_cnt        <= '0;
      vld_p1         <= 1'b0;
      upd_pc_p1      <= '0;
      upd_taken_p1   <= 1'b0;
      flush_p1       <= 1'b0;
      redirect_p1    <= '0;
      order_err_p1   <= 1'b0;
      branch_cnt_p1  <= '0;
      mispred_cnt_p1 <= '0;
    end else begin
      vld_p1   <= res_ok;
      flush_p1 <= 1'b0;
      if (res_ok) begin
        upd_pc_p1     <= i_res_pc;
        upd_taken_p1  <= i_res_taken;
        branch_cnt_p1 <= sat_inc(branch_cnt_p1);
        if (i_res_pc != head_pc) order_err_p1 <= 1'b1;
      end
      if ((state == RUN) && i_res_valid && (count == '0)) order_err_p1 <= 1'b1;
      case (state)
        RUN: begin
          if (res_ok && mispred) begin
            state          <= FLUSH;
            flush_p1       <= 1'b1;
            redirect_p1    <= next_pc(i_res_taken, i_res_pc, i_res_target);
            mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
          end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (res_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, res_ok})
              2'b10:   count <= count + CNT_W'(1);
              2'b01:   count <= count - CNT_W'(1);
              default: count <= count;
            endcase
          end
        end
        FLUSH: begin
          state   <= RECOVER;
          rec_cnt <= REC_W'(RECOVER_CYCLES - 1);
        end
        RECOVER: begin
          if (rec_cnt == '0) state <= RUN;
          else               rec_cnt <= rec_cnt - REC_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  assign o_upd_valid   = vld_p1;
  assign o_upd_pc      = upd_pc_p1;
  assign o_upd_taken   = upd_taken_p1;
  assign o_flush       = flush_p1;
  assign o_redirect_pc = redirect_p1;
  assign o_order_err   = order_err_p1;
  assign o_branch_cnt  = branch_cnt_p1;
  assign o_mispred_cnt = mispred_cnt_p1;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases followed by random traffic
// against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int N = 32, DEPTH = 4, RC = 2;

  logic clk, rst;
  logic i_pred_valid, i_pred_taken, i_res_valid, i_res_taken;
  logic [N-1:0] i_pred_pc, i_pred_target, i_res_pc, i_res_target;
  logic o_pred_ready, o_upd_valid, o_upd_taken, o_flush, o_order_err;
  logic [N-1:0] o_upd_pc, o_redirect_pc;
  logic [31:0] o_branch_cnt, o_mispred_cnt;

  branch_resolve_unit #(.N(N), .DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .rst(rst),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken),
    .i_pred_target(i_pred_target), .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_taken(i_res_taken),
    .i_res_target(i_res_target),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc), .o_upd_taken(o_upd_taken),
    .o_flush(o_flush), .o_redirect_pc(o_redirect_pc), .o_order_err(o_order_err),
    .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic taken; logic [31:0] tgt;} pred_t;
  typedef struct packed {
    logic [31:0] pc; logic taken; logic flush; logic [31:0] redir;
    logic [31:0] bcnt; logic [31:0] mcnt;
  } upd_t;

  pred_t mq[$];
  upd_t  sb[$];
  int    blocked;
  logic  m_err;
  logic [31:0] m_b, m_m;
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock of stimulus; the model advances by the same clock.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                      input logic rt, input logic [31:0] rtg);
    logic ready, mis;
    pred_t h;
    @(negedge clk);
    i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_target = ptg;
    i_res_valid = rv; i_res_pc = rpc; i_res_taken = rt; i_res_target = rtg;
    ready = (blocked == 0) && (mq.size() < DEPTH);
    chk("pred_ready", 32'(o_pred_ready), 32'(ready));
    chk("order_err", 32'(o_order_err), 32'(m_err));
    mis = 1'b0;
    if (blocked == 0 && rv) begin
      if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.pc != rpc) m_err = 1'b1;
        mis = (h.taken != rt) || (h.taken && rt && h.tgt != rtg);
        m_b = sat(m_b);
        if (mis) m_m = sat(m_m);
        sb.push_back('{pc: rpc, taken: rt, flush: mis, redir: (rt ? rtg : rpc + 32'd4),
                       bcnt: m_b, mcnt: m_m});
      end else begin
        m_err = 1'b1;
      end
    end
    if (mis) begin
      mq.delete();
      blocked = 1 + RC;
    end else begin
      if (ready && pv) mq.push_back('{pc: ppc, taken: pt, tgt: ptg});
      if (blocked > 0) blocked--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_pred_valid = 0; i_res_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete(); blocked = 0; m_err = 1'b0; m_b = '0; m_m = '0;
    chk("rst_pred_ready", 32'(o_pred_ready), 32'd1);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_upd_valid", 32'(o_upd_valid), 32'd0);
    chk("rst_order_err", 32'(o_order_err), 32'd0);
    chk("rst_branch_cnt", o_branch_cnt, 32'd0);
    chk("rst_mispred_cnt", o_mispred_cnt, 32'd0);
  endtask

  upd_t e;
  always @(posedge clk) begin
    #1;
    if (o_upd_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_upd: got pc %h want no update", o_upd_pc);
      end else begin
        e = sb.pop_front();
        chk("upd_pc", o_upd_pc, e.pc);
        chk("upd_taken", 32'(o_upd_taken), 32'(e.taken));
        chk("flush", 32'(o_flush), 32'(e.flush));
        if (e.flush) chk("redirect_pc", o_redirect_pc, e.redir);
        chk("branch_cnt", o_branch_cnt, e.bcnt);
        chk("mispred_cnt", o_mispred_cnt, e.mcnt);
      end
    end else begin
      if (o_flush) begin
        total++; bad++;
        $display("FAIL flush_without_upd: got flush 1 want 0");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++; bad++;
        $display("FAIL missing_upd: got no update want pc %h", e.pc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rpc, rtg, ppc;
    logic rt;
    rst = 1'b1;
    i_pred_valid = 0; i_pred_pc = 0; i_pred_taken = 0; i_pred_target = 0;
    i_res_valid = 0; i_res_pc = 0; i_res_taken = 0; i_res_target = 0;
    do_reset();

    // correct not-taken
    step(1, 32'h10, 0, 32'h20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h10, 0, 0);
    idle(1);
    // direction mispredict, then recovery window
    step(1, 32'h14, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h14, 1, 32'h28);
    idle(5);
    // queue fill, refused fifth push, in-order drain
    for (int i = 0; i < 5; i++) step(1, 32'h10 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'h10 + 32'(4 * i), 0, 0);
    // target mispredict clears the queue; later resolve sees it empty
    step(1, 32'h18, 1, 32'h30, 0, 0, 0, 0);
    step(1, 32'h1C, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h18, 1, 32'h40);
    idle(4);
    step(0, 0, 0, 0, 1, 32'h1C, 0, 0);
    idle(1);
    // not-taken mispredict
    step(1, 32'h20, 1, 32'h50, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h20, 0, 0);
    idle(4);
    // simultaneous push and pop at count 1
    step(1, 32'h30, 0, 0, 0, 0, 0, 0);
    step(1, 32'h34, 0, 0, 1, 32'h30, 0, 0);
    step(0, 0, 0, 0, 1, 32'h34, 0, 0);
    // redirect wraps past the top of the address space
    step(1, 32'hFFFF_FFFC, 1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(4);
    // reset with entries in flight
    step(1, 32'h40, 0, 0, 0, 0, 0, 0);
    step(1, 32'h44, 1, 32'h80, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 1, 32'h40, 0, 0);
    idle(1);

    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      ppc = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) != 0 && mq.size() > 0) begin
        rpc = ($urandom_range(0, 19) == 0) ? {$urandom_range(0, 255), 2'b00} : mq[0].pc;
        rt  = ($urandom_range(0, 6) == 0) ? ~mq[0].taken : mq[0].taken;
        rtg = ($urandom_range(0, 4) == 0) ? $urandom : mq[0].tgt;
        step($urandom_range(0, 1) == 1, ppc, $urandom_range(0, 1) == 1, $urandom,
             1, rpc, rt, rtg);
      end else begin
        step($urandom_range(0, 1) == 1, ppc, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 15) == 0, {$urandom_range(0, 255), 2'b00},
             $urandom_range(0, 1) == 1, $urandom);
      end
    end
    idle(6);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_branch_cnt", o_branch_cnt, m_b);
    chk("final_mispred_cnt", o_mispred_cnt, m_m);
    chk("final_order_err", 32'(o_order_err), 32'(m_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
